// File: rtl/regfile_operand_stage.sv
// rtl/regfile_operand_stage.sv - register file, busy scoreboard and ALU operand output stage
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        decoded instruction handshake
//   rs1, rs2, rd               source and destination register indices
//   imm_op, alu_src            sign-extended immediate and op2 source select
//   alu_ctrl_in, reg_write_in  ALU operation (0 add, 1 bne) and rd write flag
//   wb_en, wb_addr, wb_data    ALU result writeback
//   out_valid / out_ready      ALU-facing handshake
//   op1, op2, ALU_ctrl         staged operands and operation
//   rd_out, reg_write_out      staged destination info
//   a0                         architectural contents of x10

module regfile_operand_stage #(
    parameter int Address_Width = 5,
    parameter int Data_Width    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [Address_Width-1:0] rs1,
    input  logic [Address_Width-1:0] rs2,
    input  logic [Address_Width-1:0] rd,
    input  logic [Data_Width-1:0]    imm_op,
    input  logic                     alu_src,
    input  logic                     alu_ctrl_in,
    input  logic                     reg_write_in,

    input  logic                     wb_en,
    input  logic [Address_Width-1:0] wb_addr,
    input  logic [Data_Width-1:0]    wb_data,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Data_Width-1:0]    op1,
    output logic [Data_Width-1:0]    op2,
    output logic                     ALU_ctrl,
    output logic [Address_Width-1:0] rd_out,
    output logic                     reg_write_out,
    output logic [Data_Width-1:0]    a0
);

    localparam int NumRegs = 2 ** Address_Width;
    localparam int A0Index = 10;

    logic [Data_Width-1:0] regs [NumRegs];
    logic [NumRegs-1:0]    busy;

    logic                  wb_write;
    logic [NumRegs-1:0]    wb_clear;
    logic [NumRegs-1:0]    busy_eff;
    logic [NumRegs-1:0]    issue_set;
    logic [Data_Width-1:0] rs1_data;
    logic [Data_Width-1:0] rs2_data;
    logic [Data_Width-1:0] op2_sel;
    logic                  stall;
    logic                  accept;

    // x0 is hardwired to zero, so a writeback aimed at it is dropped entirely
    assign wb_write = wb_en && (wb_addr != '0);

    always_comb begin
        wb_clear = '0;
        if (wb_write) begin
            wb_clear[wb_addr] = 1'b1;
        end
    end

    // A result landing this cycle releases its register for the hazard check,
    // which lets the dependent instruction issue together with the bypass.
    assign busy_eff = busy & ~wb_clear;

    assign stall = busy_eff[rs1]
                 | (!alu_src && busy_eff[rs2])
                 | (reg_write_in && busy_eff[rd]);

    assign in_ready = rst_n && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Combinational reads with same-cycle writeback bypass
    always_comb begin
        rs1_data = '0;
        if (rs1 != '0) begin
            if (wb_en && (wb_addr == rs1)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[rs1];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 != '0) begin
            if (wb_en && (wb_addr == rs2)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[rs2];
            end
        end
    end

    assign op2_sel = alu_src ? imm_op : rs2_data;

    always_comb begin
        issue_set = '0;
        if (accept && reg_write_in && (rd != '0)) begin
            issue_set[rd] = 1'b1;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: applying the set after the clear makes a new issue win over
    // a writeback retiring the previous writer of the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wb_clear) | issue_set;
        end
    end

    // Output stage: data only moves on accept, so it holds through backpressure
    // and after the ALU drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            op1           <= '0;
            op2           <= '0;
            ALU_ctrl      <= 1'b0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            op1           <= rs1_data;
            op2           <= op2_sel;
            ALU_ctrl      <= alu_ctrl_in;
            rd_out        <= rd;
            reg_write_out <= reg_write_in;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Architectural view only; the bypass path is deliberately not visible here
    assign a0 = regs[A0Index];

endmodule

// File: tb/tb_regfile_operand_stage.sv
// tb/tb_regfile_operand_stage.sv - directed table-driven bench for regfile_operand_stage

module tb_regfile_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_op;
    logic        alu_src;
    logic        alu_ctrl_in;
    logic        reg_write_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1, op2;
    logic        ALU_ctrl;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [31:0] a0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_operand_stage #(
        .Address_Width(5),
        .Data_Width(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .imm_op       (imm_op),
        .alu_src      (alu_src),
        .alu_ctrl_in  (alu_ctrl_in),
        .reg_write_in (reg_write_in),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .op1          (op1),
        .op2          (op2),
        .ALU_ctrl     (ALU_ctrl),
        .rd_out       (rd_out),
        .reg_write_out(reg_write_out),
        .a0           (a0)
    );

    typedef struct {
        int          iv, rs1, rs2, rd;
        logic [31:0] imm;
        int          src, ctrl, rw, wbe, wba;
        logic [31:0] wbd;
        int          ordy;
        int          e_ir, e_ov;
        logic [31:0] e_op1, e_op2;
        int          e_ctrl, e_rd, e_rw;
        logic [31:0] e_a0;
    } vec_t;

    localparam int NumVec = 17;
    vec_t vec [NumVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int iv, input int r1, input int r2, input int d,
                         input logic [31:0] imm, input int src, input int ctrl, input int rw,
                         input int wbe, input int wba, input logic [31:0] wbd, input int ordy);
        in_valid     = iv[0];
        rs1          = r1[4:0];
        rs2          = r2[4:0];
        rd           = d[4:0];
        imm_op       = imm;
        alu_src      = src[0];
        alu_ctrl_in  = ctrl[0];
        reg_write_in = rw[0];
        wb_en        = wbe[0];
        wb_addr      = wba[4:0];
        wb_data      = wbd;
        out_ready    = ordy[0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'd0, 1, 0, 0, 0, 0, 32'd0, 1);
    endtask

    initial begin
        // iv rs1 rs2 rd imm src ctrl rw wbe wba wbd ordy | ir ov op1 op2 ctrl rd rw a0
        vec[0]  = '{0,  0, 0,  0, 32'd0,        1, 0, 0, 0,  0, 32'd0,        1,  1, 0, 32'd0,    32'd0,        0,  0, 0, 32'd0};
        vec[1]  = '{1,  0, 0, 10, 32'd7,        1, 0, 1, 0,  0, 32'd0,        1,  1, 1, 32'd0,    32'd7,        0, 10, 1, 32'd0};
        vec[2]  = '{1, 10, 0, 11, 32'd1,        1, 0, 1, 0,  0, 32'd0,        1,  0, 0, 32'd0,    32'd7,        0, 10, 1, 32'd0};
        vec[3]  = '{1, 10, 0, 11, 32'd1,        1, 0, 1, 1, 10, 32'd7,        1,  1, 1, 32'd7,    32'd1,        0, 11, 1, 32'd7};
        vec[4]  = '{0,  0, 0,  0, 32'd0,        1, 0, 0, 1, 11, 32'd8,        1,  1, 0, 32'd7,    32'd1,        0, 11, 1, 32'd7};
        vec[5]  = '{0,  0, 0,  0, 32'd0,        1, 0, 0, 1,  1, 32'd5,        1,  1, 0, 32'd7,    32'd1,        0, 11, 1, 32'd7};
        vec[6]  = '{0,  0, 0,  0, 32'd0,        1, 0, 0, 1,  2, 32'd5,        1,  1, 0, 32'd7,    32'd1,        0, 11, 1, 32'd7};
        vec[7]  = '{1,  1, 2,  5, 32'h1234,     0, 1, 0, 0,  0, 32'd0,        1,  1, 1, 32'd5,    32'd5,        1,  5, 0, 32'd7};
        vec[8]  = '{1,  5, 0,  0, 32'd0,        0, 0, 1, 0,  0, 32'd0,        1,  1, 1, 32'd0,    32'd0,        0,  0, 1, 32'd7};
        vec[9]  = '{1,  0, 0,  3, 32'd0,        0, 0, 1, 1,  0, 32'hFFFF_FFFF, 1, 1, 1, 32'd0,    32'd0,        0,  3, 1, 32'd7};
        vec[10] = '{1,  3, 11, 4, 32'd0,        0, 0, 1, 0,  0, 32'd0,        1,  0, 0, 32'd0,    32'd0,        0,  3, 1, 32'd7};
        vec[11] = '{1,  3, 11, 4, 32'd0,        0, 0, 1, 0,  0, 32'd0,        1,  0, 0, 32'd0,    32'd0,        0,  3, 1, 32'd7};
        vec[12] = '{1,  3, 11, 4, 32'd0,        0, 0, 1, 1,  3, 32'h55,       1,  1, 1, 32'h55,   32'd8,        0,  4, 1, 32'd7};
        vec[13] = '{1,  0, 0,  4, 32'hFFFF_FFFF, 1, 0, 1, 0,  0, 32'd0,       1,  0, 0, 32'h55,   32'd8,        0,  4, 1, 32'd7};
        vec[14] = '{1,  0, 0,  4, 32'hFFFF_FFFF, 1, 0, 1, 1,  4, 32'd9,       1,  1, 1, 32'd0,    32'hFFFF_FFFF, 0, 4, 1, 32'd7};
        vec[15] = '{1,  4, 0,  6, 32'd0,        0, 0, 0, 0,  0, 32'd0,        1,  0, 0, 32'd0,    32'hFFFF_FFFF, 0, 4, 1, 32'd7};
        vec[16] = '{1,  4, 0,  6, 32'd0,        0, 0, 0, 1,  4, 32'h99,       1,  1, 1, 32'h99,   32'd0,        0,  6, 0, 32'd7};

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a0",        a0,             32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_op1",       op1,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            drive(vec[i].iv, vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].imm, vec[i].src,
                  vec[i].ctrl, vec[i].rw, vec[i].wbe, vec[i].wba, vec[i].wbd, vec[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_ir[0]));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid),     32'(vec[i].e_ov[0]));
            chk($sformatf("v%0d_op1", i),       op1,                vec[i].e_op1);
            chk($sformatf("v%0d_op2", i),       op2,                vec[i].e_op2);
            chk($sformatf("v%0d_alu_ctrl", i),  32'(ALU_ctrl),      32'(vec[i].e_ctrl[0]));
            chk($sformatf("v%0d_rd_out", i),    32'(rd_out),        32'(vec[i].e_rd[4:0]));
            chk($sformatf("v%0d_reg_write", i), 32'(reg_write_out), 32'(vec[i].e_rw[0]));
            chk($sformatf("v%0d_a0", i),        a0,                 vec[i].e_a0);
        end

        // Backpressure: hold the staged x1 + 0x10 while the ALU refuses it
        @(negedge clk);
        drive(1, 1, 0, 0, 32'h10, 1, 0, 0, 0, 0, 32'd0, 1);
        @(posedge clk);
        #1;
        chk("bp_load_op1", op1, 32'd5);
        chk("bp_load_op2", op2, 32'h10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1, 10, 0, 0, 32'h20, 1, 0, 0, 0, 0, 32'd0, 0);
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_op1", c), op1, 32'd5);
            chk($sformatf("bp%0d_op2", c), op2, 32'h10);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(out_valid), 32'd1);
        chk("bp_release_op1", op1, 32'd7);
        chk("bp_release_op2", op2, 32'h20);

        // a0 shows the architectural value, not the in-flight writeback
        @(negedge clk);
        drive(0, 0, 0, 0, 32'd0, 1, 0, 0, 1, 10, 32'h77, 1);
        #1;
        chk("a0_no_bypass", a0, 32'd7);
        @(posedge clk);
        #1;
        chk("a0_written", a0, 32'h77);

        // Reset in the middle of traffic: staged instruction and busy[7] vanish
        @(negedge clk);
        drive(1, 0, 0, 7, 32'd3, 1, 0, 1, 0, 0, 32'd0, 1);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_a0",        a0,             32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_op2",       op2,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 5, 10, 7, 32'd0, 0, 0, 1, 0, 0, 32'd0, 1);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_op1", op1, 32'd0);
        chk("post_rst_op2", op2, 32'd0);
        chk("post_rst_rd_out", 32'(rd_out), 32'd7);

        @(negedge clk);
        idle();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
